// File: rtl/rand_req_scheduler.sv
// Round-robin front end that shares one external 24-bit Fibonacci LFSR among NUM_REQ requesters.
// Optional build macro RAND_REJECT_EN adds rand_limit with bounded re-stepping of out-of-range values.
module rand_req_scheduler #(
    parameter int               NUM_REQ   = 4,
    parameter int               WIDTH     = 24,
    parameter int               SHIFTS    = 24,
    parameter logic [WIDTH-1:0] SAFE_SEED = 24'h00000F,
    parameter int               MAX_RETRY = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] done,
    output logic [WIDTH-1:0]   rand_out,
    output logic               rand_valid,
    output logic               busy,
    input  logic               seed_wr,
    input  logic [WIDTH-1:0]   seed_in,
    output logic               lfsr_en,
    output logic               lfsr_load,
    output logic [WIDTH-1:0]   lfsr_seed,
    input  logic [WIDTH-1:0]   lfsr_q
`ifdef RAND_REJECT_EN
    ,
    input  logic [WIDTH-1:0]   rand_limit
`endif
);
    localparam int         IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] LAST_STEP = 8'(SHIFTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_DELIVER} state_t;

    state_t             r_state;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_grant;
    logic [7:0]         r_step;
    logic               r_seed_pend;
    logic [WIDTH-1:0]   r_seed_val;
    logic               r_accepted;
    logic [NUM_REQ-1:0] r_done;
    logic [WIDTH-1:0]   r_rand_out;
    logic               r_valid;
    logic               r_lfsr_en;
    logic               r_lfsr_load;
    logic [WIDTH-1:0]   r_lfsr_seed;

    logic [NUM_REQ-1:0] w_req_rot;
    logic               w_any;
    logic [IW-1:0]      w_off;
    logic [IW:0]        w_sum;
    logic [IW-1:0]      w_pick;
    logic [IW-1:0]      w_ptr_nxt;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic               w_seed_pend;
    logic [WIDTH-1:0]   w_seed_val;
    logic [WIDTH-1:0]   w_lfsr_next;
    logic               w_accept;
    logic [WIDTH-1:0]   w_value;

    // Rotate requests so offset 0 is the RR pointer, then take the lowest set offset.
    assign w_req_rot = NUM_REQ'({req, req} >> r_ptr);

    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_any = 1'b1;
                w_off = IW'(i);
            end
        end
    end

    assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_pick     = (w_sum >= (IW+1)'(NUM_REQ)) ? IW'(w_sum - (IW+1)'(NUM_REQ)) : IW'(w_sum);
    assign w_ptr_nxt  = (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + IW'(1);
    assign w_grant_oh = NUM_REQ'(1) << r_grant;

    // A strobe arriving while idle is acted on at once instead of waiting a cycle in the pending register.
    assign w_seed_pend = r_seed_pend | seed_wr;
    assign w_seed_val  = seed_wr ? seed_in : r_seed_val;

    // The last step lands on the same edge that closes STEP, so the delivered value is predicted from the taps.
    assign w_lfsr_next = {lfsr_q[WIDTH-2:0], lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16]};

`ifdef RAND_REJECT_EN
    localparam int RW = $clog2(MAX_RETRY + 1);
    logic [RW-1:0] r_retry;
    logic          w_over;

    assign w_over   = w_lfsr_next > rand_limit;
    assign w_accept = !w_over || (r_retry >= RW'(MAX_RETRY));
    assign w_value  = w_over ? rand_limit : w_lfsr_next;
`else
    assign w_accept = 1'b1;
    assign w_value  = w_lfsr_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_step      <= '0;
            r_seed_pend <= 1'b0;
            r_seed_val  <= '0;
            r_accepted  <= 1'b0;
            r_done      <= '0;
            r_rand_out  <= '0;
            r_valid     <= 1'b0;
            r_lfsr_en   <= 1'b0;
            r_lfsr_load <= 1'b0;
            r_lfsr_seed <= '0;
`ifdef RAND_REJECT_EN
            r_retry     <= '0;
`endif
        end else begin
            r_done      <= '0;
            r_valid     <= 1'b0;
            r_lfsr_load <= 1'b0;
            if (seed_wr) begin
                r_seed_pend <= 1'b1;
                r_seed_val  <= seed_in;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_seed_pend) begin
                        r_state     <= S_LOAD;
                        r_lfsr_load <= 1'b1;
                        r_lfsr_seed <= (w_seed_val == '0) ? SAFE_SEED : w_seed_val;
                        r_seed_pend <= 1'b0;
                    end else if (w_any) begin
                        r_state   <= S_STEP;
                        r_grant   <= w_pick;
                        r_step    <= '0;
                        r_lfsr_en <= 1'b1;
`ifdef RAND_REJECT_EN
                        r_retry   <= '0;
`endif
                    end
                end
                S_LOAD: r_state <= S_IDLE;
                S_STEP: begin
                    if (r_step == LAST_STEP) begin
                        r_lfsr_en  <= 1'b0;
                        r_state    <= S_DELIVER;
                        r_accepted <= w_accept;
                        if (w_accept) begin
                            r_done     <= w_grant_oh;
                            r_valid    <= 1'b1;
                            r_rand_out <= w_value;
                        end
                    end else begin
                        r_step <= r_step + 8'd1;
                    end
                end
                S_DELIVER: begin
                    if (r_accepted) begin
                        r_ptr   <= w_ptr_nxt;
                        r_state <= S_IDLE;
                    end else begin
                        r_state   <= S_STEP;
                        r_step    <= '0;
                        r_lfsr_en <= 1'b1;
`ifdef RAND_REJECT_EN
                        r_retry   <= r_retry + RW'(1);
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign done       = r_done;
    assign rand_out   = r_rand_out;
    assign rand_valid = r_valid;
    assign busy       = (r_state != S_IDLE);
    assign lfsr_en    = r_lfsr_en;
    assign lfsr_load  = r_lfsr_load;
    assign lfsr_seed  = r_lfsr_seed;

endmodule

// File: tb/tb_rand_req_scheduler.sv
// Bench for rand_req_scheduler: owns the LFSR it steers and checks grants and values against a reference model.
`timescale 1ns/1ps
module tb_rand_req_scheduler;
    localparam int          N    = 4;
    localparam int          S    = 24;
    localparam logic [23:0] SAFE = 24'h00000F;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [23:0] rand_out;
    logic        rand_valid;
    logic        busy;
    logic        seed_wr;
    logic [23:0] seed_in;
    logic        lfsr_en;
    logic        lfsr_load;
    logic [23:0] lfsr_seed;
    logic [23:0] env_lfsr;
`ifdef RAND_REJECT_EN
    logic [23:0] rand_limit;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_ptr;
    logic [23:0] m_state;
    bit          pend_valid;
    logic [23:0] pend_val;

    typedef struct {
        logic [3:0] mask;
        int         grant;
    } vec_t;
    vec_t vecs[8];

    int          order[5] = '{0, 1, 2, 3, 0};
    int          ec, nd, last_t, low_run, max_low, rmask, ridx, rlat, rseed_at;
    bit          rdrop;
    logic [23:0] ev, rseed;

    rand_req_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .rand_out  (rand_out),
        .rand_valid(rand_valid),
        .busy      (busy),
        .seed_wr   (seed_wr),
        .seed_in   (seed_in),
        .lfsr_en   (lfsr_en),
        .lfsr_load (lfsr_load),
        .lfsr_seed (lfsr_seed),
        .lfsr_q    (env_lfsr)
`ifdef RAND_REJECT_EN
        ,
        .rand_limit(rand_limit)
`endif
    );

    always #5 clk = ~clk;

    // The shared LFSR the scheduler drives; it powers up in the safe seed state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          env_lfsr <= SAFE;
        else if (lfsr_load) env_lfsr <= lfsr_seed;
        else if (lfsr_en)   env_lfsr <= {env_lfsr[22:0], env_lfsr[23] ^ env_lfsr[22] ^ env_lfsr[21] ^ env_lfsr[16]};
    end

    function automatic logic [23:0] adv(input logic [23:0] s, input int n);
        logic [23:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = {v[22:0], ^(v & 24'hE10000)};
        return v;
    endfunction

    function automatic int rr_pick(input logic [3:0] m, input int p);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (p + k) % N;
            if (m[j[1:0]]) return j;
        end
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        check({tag, "_done"},       32'(done),       0);
        check({tag, "_rand_out"},   32'(rand_out),   0);
        check({tag, "_rand_valid"}, 32'(rand_valid), 0);
        check({tag, "_busy"},       32'(busy),       0);
        check({tag, "_lfsr_en"},    32'(lfsr_en),    0);
        check({tag, "_lfsr_load"},  32'(lfsr_load),  0);
        check({tag, "_lfsr_seed"},  32'(lfsr_seed),  0);
    endtask

    // Called #1 after a rising edge with the scheduler idle.
    task automatic do_grant(input logic [3:0] mask, input int exp_idx, input int exp_lat,
                            input int seed_at, input logic [23:0] seed_v, input bit drop);
        logic [23:0] exp_seed, exp_val;
        bit          exp_load, got, overlap, load_bad;
        int          en_cnt, load_cnt, lat;
        exp_load = pend_valid;
        exp_seed = (pend_val == 24'd0) ? SAFE : pend_val;
        if (pend_valid) begin
            m_state    = exp_seed;
            pend_valid = 1'b0;
        end
        exp_val  = adv(m_state, S);
        got      = 1'b0;
        overlap  = 1'b0;
        load_bad = 1'b0;
        en_cnt   = 0;
        load_cnt = 0;
        lat      = 0;
        req      = mask;
        for (int c = 1; c <= 80 && !got; c++) begin
            @(negedge clk);
            if (seed_wr) seed_wr = 1'b0;
            if (lfsr_en) en_cnt++;
            if (lfsr_en && lfsr_load) overlap = 1'b1;
            if (lfsr_load) begin
                load_cnt++;
                if (lfsr_seed !== exp_seed) load_bad = 1'b1;
            end
            if (done != 4'b0) begin
                got = 1'b1;
                lat = c;
            end
            if (c == seed_at) begin
                seed_wr    = 1'b1;
                seed_in    = seed_v;
                pend_valid = 1'b1;
                pend_val   = seed_v;
            end
            if (drop && c == 8) req = 4'b0;
        end
        check("done_seen",    32'(got),        1);
        check("done_onehot",  32'(done),       32'(4'(1) << exp_idx));
        check("rand_out",     32'(rand_out),   32'(exp_val));
        check("rand_valid",   32'(rand_valid), 1);
        check("step_count",   en_cnt,          S);
        check("latency",      lat,             exp_lat);
        check("load_count",   load_cnt,        exp_load ? 1 : 0);
        check("load_seed",    32'(load_bad),   0);
        check("en_load_excl", 32'(overlap),    0);
        m_state = exp_val;
        m_ptr   = (exp_idx + 1) % N;
        @(posedge clk);
        #1;
        req = 4'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{4'b0001, 0};
        vecs[1] = '{4'b0001, 0};
        vecs[2] = '{4'b1100, 2};
        vecs[3] = '{4'b0110, 1};
        vecs[4] = '{4'b1001, 3};
        vecs[5] = '{4'b1010, 1};
        vecs[6] = '{4'b0100, 2};
        vecs[7] = '{4'b1111, 3};

        reset      = 1'b1;
        req        = 4'b0;
        seed_wr    = 1'b0;
        seed_in    = 24'd0;
`ifdef RAND_REJECT_EN
        rand_limit = '1;
`endif
        m_ptr      = 0;
        m_state    = SAFE;
        pend_valid = 1'b0;
        pend_val   = 24'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) do_grant(vecs[i].mask, vecs[i].grant, 26, -1, 24'd0, 1'b0);

        // Zero seed written while idle: load of the safe seed on the following cycle.
        seed_wr = 1'b1;
        seed_in = 24'd0;
        @(negedge clk);
        check("pre_load", 32'(lfsr_load), 0);
        @(posedge clk);
        #1;
        seed_wr = 1'b0;
        @(negedge clk);
        check("zero_seed_load",  32'(lfsr_load), 1);
        check("zero_seed_val",   32'(lfsr_seed), 32'(SAFE));
        check("zero_seed_no_en", 32'(lfsr_en),   0);
        m_state = SAFE;
        @(negedge clk);
        check("load_one_cycle", 32'(lfsr_load), 0);
        @(posedge clk);
        #1;

        // Reseed during req0's run while req1 waits: req0 finishes, then LOAD, then req1.
        do_grant(4'b0011, 0, 26, 10, 24'hABCDEF, 1'b0);
        do_grant(4'b0010, 1, 28, -1, 24'd0, 1'b0);

        // Asynchronous reset partway through a run.
        req = 4'b0001;
        ec  = 0;
        for (int c = 0; c < 60 && ec < 10; c++) begin
            @(negedge clk);
            if (lfsr_en) ec++;
        end
        check("midrst_reached", ec, 10);
        reset = 1'b1;
        #1;
        chk_idle_outputs("midrst");
        @(negedge clk);
        reset      = 1'b0;
        req        = 4'b0;
        m_ptr      = 0;
        m_state    = SAFE;
        pend_valid = 1'b0;
        @(posedge clk);
        #1;

        // All requesters held: rotation from pointer 0, fixed spacing, busy dips one cycle at most.
        req     = 4'b1111;
        nd      = 0;
        last_t  = 0;
        low_run = 0;
        max_low = 0;
        for (int c = 1; c <= 200 && nd < 5; c++) begin
            @(negedge clk);
            if (!busy) begin
                low_run++;
                if (low_run > max_low) max_low = low_run;
            end else begin
                low_run = 0;
            end
            if (done != 4'b0) begin
                ev = adv(m_state, S);
                check("rr_order",   32'(done),     32'(4'(1) << order[nd]));
                check("rr_value",   32'(rand_out), 32'(ev));
                check("rr_spacing", c - last_t,    26);
                m_state = ev;
                last_t  = c;
                nd++;
            end
        end
        check("rr_grants", nd, 5);
        check("busy_gap",  max_low, 1);
        m_ptr = 1;
        @(posedge clk);
        #1;
        req = 4'b0;

        // Randomized traffic with occasional reseeds and dropped requests.
        for (int it = 0; it < 20; it++) begin
            rmask    = int'($urandom_range(1, 15));
            ridx     = rr_pick(rmask[3:0], m_ptr);
            rlat     = pend_valid ? 28 : 26;
            rseed_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 20)) : -1;
            rseed    = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom);
            rdrop    = ($urandom_range(0, 3) == 0);
            do_grant(rmask[3:0], ridx, rlat, rseed_at, rseed, rdrop);
        end

`ifdef RAND_REJECT_EN
        // Every value exceeds a zero limit, so all retries are spent and the limit itself is delivered.
        rand_limit = 24'd0;
        req        = 4'b0010;
        ec         = 0;
        nd         = 0;
        for (int c = 0; c < 400 && nd == 0; c++) begin
            @(negedge clk);
            if (lfsr_en) ec++;
            if (done != 4'b0) nd = 1;
        end
        check("rej_done",  32'(done),     32'(4'b0010));
        check("rej_value", 32'(rand_out), 0);
        check("rej_steps", ec,            192);
        @(posedge clk);
        #1;
        req        = 4'b0;
        rand_limit = '1;
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
